// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StResp
  } lsu_state_e;

  // A store funct3 of 3'b011 has no 32-bit meaning either, so it is rejected too.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3[2] | (f3[1:0] == 2'b11);
    end
    return (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extract/extend for loads, byte/half merge for stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [31:0] shifted;
  assign shifted = rd_word_i >> {byte_off_i, 3'b000};

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = rd_word_i;
      F3_BU:   load_data_o = {24'h0, shifted[7:0]};
      F3_HU:   load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    store_word_o = merge_word_i;
    case (funct3_i)
      F3_B:    store_word_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H:    store_word_o[{byte_off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns byte-addressed load/store requests into word accesses,
// with sub-word read-modify-write and error detection.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DepthW = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_rw_o,
  input  logic [31:0] mem_rd_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        req_err;

  assign req_err = f3_illegal(req_we_i, req_funct3_i)
                 | misaligned(req_funct3_i, req_addr_i[1:0])
                 | (|req_addr_i[31:DepthW+2]);

  lsu_align u_align (
    .funct3_i    (funct3_q),
    .byte_off_i  (addr_q[1:0]),
    .rd_word_i   (mem_rd_i),
    .merge_word_i(merge_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .store_word_o(store_word)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          funct3_d = req_funct3_i;
          wdata_d  = req_wdata_i;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err)                        state_d = StResp;
          else if (!req_we_i)                 state_d = StLoad;
          else if (req_funct3_i[1:0] == 2'b10) state_d = StWrite;
          else                                state_d = StRmwRd;
        end
      end
      StLoad: begin
        rdata_d = load_data;
        state_d = StResp;
      end
      StRmwRd: begin
        merge_d = mem_rd_i;
        state_d = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign mem_addr_o  = (state_q == StIdle) ? '0 : {2'b00, addr_q[31:2]};
  assign mem_rw_o    = (state_q == StWrite);
  assign mem_wd_o    = mem_rw_o ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic checked against a
// byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
  logic        mem_rw;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_checks = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DepthW(10)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_funct3_i(req_funct3),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_addr_o  (mem_addr),
    .mem_wd_o    (mem_wd),
    .mem_rw_o    (mem_rw),
    .mem_rd_i    (mem_rd)
  );

  assign mem_rd = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_rw) mem[mem_addr[9:0]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: access size from funct3, byte lanes little-endian, memory as bytes in words.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output int lat, output int writes);
    int unsigned size, off, widx;
    logic legal;
    logic [31:0] word, val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = addr % 4;
    widx = addr / 4;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    err = !legal || (addr % size != 0) || (widx >= 1024);
    rdata = 0;
    writes = 0;
    lat = 1;
    if (err) return;
    word = ref_mem[widx];
    if (!we) begin
      lat = 2;
      val = word >> (8 * off);
      if (size < 4) begin
        val = val % (32'd1 << (8 * size));
        if (!f3[2] && val >= (32'd1 << (8 * size - 1))) val = val - (32'd1 << (8 * size));
      end
      rdata = val;
    end else begin
      writes = 1;
      lat = (size == 4) ? 2 : 3;
      for (int i = 0; i < int'(size); i++) word[8 * (off + i) +: 8] = wdata[8 * i +: 8];
      ref_mem[widx] = word;
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic e_err;
    logic [31:0] e_rd;
    int e_lat, e_wr, lat, wr;
    bit seen;
    int unsigned widx;
    model(we, f3, addr, wdata, e_err, e_rd, e_lat, e_wr);
    widx = addr >> 2;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wr = 0; seen = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (mem_rw) wr++;
      if (c == 1 && !e_err) check({tag, ".mem_addr"}, mem_addr, addr >> 2);
      if (rsp_valid) begin
        seen = 1;
        lat = c;
        check({tag, ".rdata"}, rsp_rdata, e_rd);
        check({tag, ".err"}, 32'(rsp_err), 32'(e_err));
      end
    end
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    @(negedge clk);
    if (mem_rw) wr++;
    check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
    check({tag, ".writes"}, 32'(wr), 32'(e_wr));
    if (widx < 1024) check({tag, ".memword"}, mem[widx], ref_mem[widx]);
  endtask

  initial begin
    logic [31:0] saved;
    bit bad_seen;
    logic e_err;
    logic [31:0] e_rd;
    int e_lat, e_wr, k, got, extra;
    bit acc;
    logic        q_err [$];
    logic [31:0] q_rd  [$];
    logic        b_we  [4];
    logic [2:0]  b_f3  [4];
    logic [31:0] b_ad  [4];
    logic [31:0] b_wd  [4];

    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;

    repeat (2) @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.mem_rw", 32'(mem_rw), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wd", mem_wd, 32'd0);
    check("rst.rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    do_req("lb", 1'b0, 3'b000, 32'h12, 32'h0);
    do_req("lbu", 1'b0, 3'b100, 32'h12, 32'h0);
    do_req("sh", 1'b1, 3'b001, 32'h12, 32'h00001234);
    check("sh.word4", mem[4], 32'h1234AABB);
    do_req("sw", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    do_req("lw", 1'b0, 3'b010, 32'h20, 32'h0);
    check("sw.word8", mem[8], 32'hDEADBEEF);
    do_req("err_lw_mis", 1'b0, 3'b010, 32'h22, 32'h0);
    do_req("err_sh_mis", 1'b1, 3'b001, 32'h03, 32'hFFFF);
    do_req("err_f3", 1'b0, 3'b011, 32'h0, 32'h0);
    do_req("err_range", 1'b0, 3'b010, 32'h1000, 32'h0);

    // Reset while the SB is in its read phase.
    saved = mem[8];
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.mem_rw", 32'(mem_rw), 32'd0);
    check("arst.ready", 32'(req_ready), 32'd1);
    check("arst.mem_addr", mem_addr, 32'd0);
    check("arst.mem_wd", mem_wd, 32'd0);
    check("arst.rdata", 32'(rsp_rdata), 32'd0);
    bad_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_rw || rsp_valid) bad_seen = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (mem_rw || rsp_valid) bad_seen = 1;
    end
    check("arst.quiet", 32'(bad_seen), 32'd0);
    check("arst.word8", mem[8], saved);

    // Back-to-back with req_valid held high.
    b_we = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_f3 = '{3'b010, 3'b010, 3'b000, 3'b101};
    b_ad = '{32'h40, 32'h40, 32'h41, 32'h40};
    b_wd = '{32'hCAFEF00D, 32'h0, 32'h5A, 32'h0};
    k = 0; got = 0; extra = 0;
    @(negedge clk);
    req_valid = 1; req_we = b_we[0]; req_funct3 = b_f3[0];
    req_addr = b_ad[0]; req_wdata = b_wd[0];
    for (int c = 0; c < 60 && got < 4; c++) begin
      if (rsp_valid) begin
        if (q_rd.size() == 0) begin
          check("b2b.unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          check("b2b.rdata", rsp_rdata, q_rd.pop_front());
          check("b2b.err", 32'(rsp_err), 32'(q_err.pop_front()));
        end
        got++;
      end
      acc = req_valid && req_ready;
      if (acc) begin
        model(req_we, req_funct3, req_addr, req_wdata, e_err, e_rd, e_lat, e_wr);
        q_err.push_back(e_err);
        q_rd.push_back(e_rd);
      end
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 4) begin
          req_we = b_we[k]; req_funct3 = b_f3[k]; req_addr = b_ad[k]; req_wdata = b_wd[k];
        end else begin
          req_valid = 0;
        end
      end
      @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    check("b2b.count", 32'(got), 32'd4);
    check("b2b.extra", 32'(extra), 32'd0);
    check("b2b.word16", mem[16], 32'hCAFE5A0D);

    // Random traffic over a small window plus occasional out-of-range words.
    for (int n = 0; n < 300; n++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] addr;
      int unsigned pick;
      we = 1'($urandom_range(0, 1));
      if (we) begin
        pick = $urandom_range(0, 9);
        f3 = (pick < 8) ? 3'(pick % 3) : 3'($urandom_range(4, 7));
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(1024, 4000)) << 2;
      else addr = 32'($urandom_range(0, 15)) << 2;
      addr = addr | 32'($urandom_range(0, 3));
      do_req("rnd", we, f3, addr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
